// File: rtl/uart_arb_pkg.sv
// Shared types and limits for the UART transmitter round-robin arbiter.
package uart_arb_pkg;

  localparam int UART_ARB_MAX_REQ = 8;

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_IDLE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first valid request at or above rr_ptr, wrapping.
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int GNT_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [GNT_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [GNT_W-1:0]   win_idx,
  output logic               any
);

  logic [GNT_W-1:0] cand;

  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    any        = 1'b0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = GNT_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!any && req_valid[cand]) begin
        any              = 1'b1;
        win_idx          = cand;
        win_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Optional packet lock enabled by defining UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GNT_W   = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_lock,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_ready,
  output logic [GNT_W-1:0]     gnt_id,
  output logic                 busy
);

  arb_state_t         state, next_state;
  logic [GNT_W-1:0]   rr_ptr, next_ptr;
  logic [GNT_W-1:0]   next_gnt, win_idx;
  logic [NUM_REQ-1:0] next_ack;
  logic [7:0]         next_data;
  logic               next_start;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [GNT_W-1:0]   pick_idx;
  logic               pick_any;
  logic               lock_hold;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GNT_W   (GNT_W)
  ) u_pick (
    .req_valid  (req_valid),
    .rr_ptr     (rr_ptr),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .any        (pick_any)
  );

`ifdef UART_TX_ARB_LOCK_EN
  // The previous winner keeps the transmitter while it holds lock and has a byte.
  assign lock_hold = req_lock[gnt_id] & req_valid[gnt_id];
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign lock_hold   = 1'b0;
`endif

  assign win_idx = lock_hold ? gnt_id : pick_idx;

  always_comb begin
    next_state = state;
    next_start = tx_start;
    next_ack   = '0;
    next_data  = tx_data;
    next_gnt   = gnt_id;
    next_ptr   = rr_ptr;
    case (state)
      ARB: begin
        if (pick_any && tx_ready) begin
          next_state = START;
          next_start = 1'b1;
          next_gnt   = win_idx;
          next_data  = req_data[{win_idx, 3'b000} +: 8];
          if (lock_hold) begin
            next_ack = NUM_REQ'(1) << gnt_id;
          end else begin
            next_ack = pick_onehot;
            next_ptr = (pick_idx == GNT_W'(NUM_REQ - 1)) ? '0 : pick_idx + GNT_W'(1);
          end
        end
      end
      // Start is held through the drop of ready; the transmitter latches on start&ready.
      START: begin
        if (!tx_ready) begin
          next_start = 1'b0;
          next_state = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (tx_ready) next_state = ARB;
      end
      default: begin
        next_state = ARB;
        next_start = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ARB;
      rr_ptr   <= '0;
      req_ack  <= '0;
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
      gnt_id   <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= next_state;
      rr_ptr   <= next_ptr;
      req_ack  <= next_ack;
      tx_data  <= next_data;
      tx_start <= next_start;
      gnt_id   <= next_gnt;
      busy     <= (next_state != ARB);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: scoreboard of expected grants plus a
// behavioural transmitter that drops ready for a fixed frame length.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int GW    = 2;
  localparam int FRAME = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid, req_lock, req_ack;
  logic [8*N-1:0] req_data;
  logic [7:0]     tx_data;
  logic           tx_start, tx_ready, busy;
  logic [GW-1:0]  gnt_id;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_tx[$];
  logic [7:0] tx_log[$];
  logic [7:0] pred[N];
  int         left[N];
  int         lock_left;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         hold_ready = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(N), .GNT_W(GW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_lock  (req_lock),
    .req_ack   (req_ack),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_ready  (tx_ready),
    .gnt_id    (gnt_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Transmitter model: latches on start&ready, busy for FRAME cycles.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (hold_ready) begin
        tx_ready = 1'b0;
      end else if (tx_start === 1'b1 && tx_ready) begin
        tx_log.push_back(tx_data);
        tx_ready = 1'b0;
        repeat (FRAME) @(negedge clk);
        tx_ready = 1'b1;
      end else begin
        tx_ready = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input int id, input logic [7:0] first, input int cnt);
    req_data[8*id +: 8] = first;
    req_valid[id]       = 1'b1;
    left[id]            = cnt;
    pred[id]            = first;
  endtask

  task automatic push_exp(input int id);
    exp_t e;
    e.id   = id;
    e.data = pred[id];
    sb.push_back(e);
    exp_tx.push_back(pred[id]);
    pred[id] = pred[id] + 8'd1;
  endtask

  // Observe acks for up to budget cycles, comparing each against the scoreboard
  // and letting the acked requester move on to its next byte.
  task automatic run_grants(input int n, input int budget);
    int   got = 0;
    int   cyc = 0;
    exp_t e;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (req_ack !== '0) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $error("FAIL unexpected_ack: observed 0x%0h expected none", req_ack);
        end else begin
          e = sb.pop_front();
          check("req_ack", 32'(req_ack), 32'(1) << e.id);
          check("gnt_id", 32'(gnt_id), 32'(e.id));
          check("tx_data", 32'(tx_data), 32'(e.data));
          check("tx_start_at_grant", 32'(tx_start), 32'd1);
        end
        for (int i = 0; i < N; i++) begin
          if (req_ack[i]) begin
            req_data[8*i +: 8] = req_data[8*i +: 8] + 8'd1;
            left[i]--;
            if (left[i] <= 0) req_valid[i] = 1'b0;
            if (i == 1 && lock_left > 0) begin
              lock_left--;
              if (lock_left == 0) req_lock[1] = 1'b0;
            end
          end
        end
        got++;
      end
    end
    if (got < n) begin
      n_cmp++;
      n_bad++;
      $error("FAIL grant_timeout: observed %0d grants expected %0d", got, n);
    end
  endtask

  task automatic wait_idle(input int budget);
    int cyc = 0;
    @(negedge clk);
    while (!(busy === 1'b0 && tx_ready === 1'b1 && tx_start === 1'b0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= budget) begin
      n_cmp++;
      n_bad++;
      $error("FAIL idle_timeout: observed busy=%0b expected 0", busy);
    end
  endtask

  task automatic check_log();
    logic [7:0] want;
    while (exp_tx.size() > 0) begin
      want = exp_tx.pop_front();
      if (tx_log.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL tx_log_missing: observed none expected 0x%0h", want);
      end else begin
        check("tx_byte", 32'(tx_log.pop_front()), 32'(want));
      end
    end
    check("tx_log_extra", 32'(tx_log.size()), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_lock  = '0;
    req_data  = '0;
    lock_left = 0;
    for (int i = 0; i < N; i++) begin
      left[i] = 0;
      pred[i] = 8'h00;
    end

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_req_ack", 32'(req_ack), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_gnt_id", 32'(gnt_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;

    // All four requesters continuously valid: strict 0,1,2,3 rotation.
    for (int i = 0; i < N; i++) start_req(i, 8'(8'h10 * (i + 1)), 2);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push_exp(i);
    run_grants(8, 200);
    wait_idle(40);
    check_log();

    // Single request from 2; start held until ready drops, then busy in WAIT_IDLE.
    start_req(2, 8'hA5, 1);
    push_exp(2);
    run_grants(1, 20);
    @(negedge clk);
    check("single_start_cleared", 32'(tx_start), 32'd0);
    check("single_busy", 32'(busy), 32'd1);
    check("single_ack_one_cycle", 32'(req_ack), 32'd0);
    wait_idle(40);
    check_log();

    // Transmitter not ready: no grant until ready rises, then on the next edge.
    @(posedge clk);
    hold_ready = 1'b1;
    @(negedge clk);
    start_req(1, 8'h3C, 1);
    push_exp(1);
    repeat (3) @(negedge clk);
    check("notready_ack", 32'(req_ack), 32'd0);
    check("notready_start", 32'(tx_start), 32'd0);
    check("notready_busy", 32'(busy), 32'd0);
    @(posedge clk);
    hold_ready = 1'b0;
    run_grants(1, 2);
    wait_idle(40);
    check_log();

    // Reset while waiting for the frame to finish; pointer returns to 0.
    start_req(1, 8'h77, 1);
    push_exp(1);
    run_grants(1, 20);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_tx_start", 32'(tx_start), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ack", 32'(req_ack), 32'd0);
    check("midrst_gnt_id", 32'(gnt_id), 32'd0);
    reset_n = 1'b1;
    start_req(3, 8'hC3, 1);
    start_req(0, 8'h0F, 1);
    push_exp(0);
    push_exp(3);
    run_grants(2, 60);
    wait_idle(40);
    check_log();

    // Move the pointer to 1, then req 1 locks for three bytes against 0 and 2.
    start_req(0, 8'h01, 1);
    push_exp(0);
    run_grants(1, 20);
    wait_idle(40);
    check_log();
    start_req(0, 8'h50, 1);
    start_req(1, 8'h60, 4);
    start_req(2, 8'h70, 1);
    req_lock[1] = 1'b1;
    lock_left   = 3;
`ifdef UART_TX_ARB_LOCK_EN
    push_exp(1); push_exp(1); push_exp(1); push_exp(2); push_exp(0); push_exp(1);
`else
    push_exp(1); push_exp(2); push_exp(0); push_exp(1); push_exp(1); push_exp(1);
`endif
    run_grants(6, 200);
    wait_idle(40);
    check_log();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
